// File: rtl/soc_bus_ctrl.sv
// Single-master bus controller: decodes a slave-select field from the address,
// strobes one slave until it acks or times out, and reports completion/error.
module soc_bus_ctrl #(
    parameter int          NSLV     = 4,
    parameter int          DW       = 32,
    parameter int          SEL_LSB  = 8,
    parameter int          TIMEOUT  = 8,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               m_req,
    input  logic               m_we,
    input  logic [31:0]        m_addr,
    input  logic [DW-1:0]      m_wdata,
    output logic [DW-1:0]      m_rdata,
    output logic               m_ready,
    output logic               m_err,
    output logic               busy,
    output logic [NSLV-1:0]    s_we,
    output logic [NSLV-1:0]    s_re,
    output logic [31:0]        s_addr,
    output logic [DW-1:0]      s_wdata,
    input  logic [NSLV*DW-1:0] s_rdata,
    input  logic [NSLV-1:0]    s_ack,
    output logic [7:0]         err_count
);

    localparam int SW = (NSLV > 1) ? $clog2(NSLV) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [DW-1:0] ERR_WORD = DW'(ERR_DATA);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t         state_r;
    logic [SW-1:0]  sel_r;
    logic           we_r;
    logic [CW-1:0]  cnt_r;

    logic [SW-1:0]   sel_s;
    logic            sel_ok_s;
    logic [NSLV-1:0] onehot_s;
    logic            ack_s;
    logic [DW-1:0]   rdata_s;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? 8'hFF : v + 8'd1;
    endfunction

    // Address decode for the incoming request and selection of the active slave's ack/data.
    always_comb begin
        sel_s    = m_addr[SEL_LSB +: SW];
        sel_ok_s = ({1'b0, sel_s} < (SW+1)'(NSLV));
        onehot_s = {NSLV{1'b0}};
        ack_s    = 1'b0;
        rdata_s  = {DW{1'b0}};
        for (int i = 0; i < NSLV; i++) begin
            onehot_s[i] = (sel_s == SW'(i));
            ack_s       = ack_s | (s_ack[i] & (sel_r == SW'(i)));
            rdata_s     = rdata_s | (s_rdata[i*DW +: DW] & {DW{sel_r == SW'(i)}});
        end
    end

    // Transaction FSM with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            sel_r     <= {SW{1'b0}};
            we_r      <= 1'b0;
            cnt_r     <= {CW{1'b0}};
            m_rdata   <= {DW{1'b0}};
            m_ready   <= 1'b0;
            m_err     <= 1'b0;
            busy      <= 1'b0;
            s_we      <= {NSLV{1'b0}};
            s_re      <= {NSLV{1'b0}};
            s_addr    <= 32'd0;
            s_wdata   <= {DW{1'b0}};
            err_count <= 8'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    m_ready <= 1'b0;
                    m_err   <= 1'b0;
                    if (m_req) begin
                        s_addr  <= m_addr;
                        s_wdata <= m_wdata;
                        we_r    <= m_we;
                        sel_r   <= sel_s;
                        busy    <= 1'b1;
                        if (sel_ok_s) begin
                            state_r <= ST_ACCESS;
                            cnt_r   <= {CW{1'b0}};
                            s_we    <= m_we ? onehot_s : {NSLV{1'b0}};
                            s_re    <= m_we ? {NSLV{1'b0}} : onehot_s;
                        end else begin
                            // Decode error skips the slave entirely.
                            state_r   <= ST_DONE;
                            m_ready   <= 1'b1;
                            m_err     <= 1'b1;
                            m_rdata   <= ERR_WORD;
                            err_count <= sat_inc(err_count);
                        end
                    end else begin
                        busy <= 1'b0;
                    end
                end
                ST_ACCESS: begin
                    if (ack_s) begin
                        // Ack takes priority over an expiring timeout.
                        state_r <= ST_DONE;
                        m_ready <= 1'b1;
                        m_err   <= 1'b0;
                        m_rdata <= we_r ? {DW{1'b0}} : rdata_s;
                        s_we    <= {NSLV{1'b0}};
                        s_re    <= {NSLV{1'b0}};
                    end else if (cnt_r == CW'(TIMEOUT - 1)) begin
                        state_r   <= ST_DONE;
                        m_ready   <= 1'b1;
                        m_err     <= 1'b1;
                        m_rdata   <= ERR_WORD;
                        s_we      <= {NSLV{1'b0}};
                        s_re      <= {NSLV{1'b0}};
                        err_count <= sat_inc(err_count);
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    m_ready <= 1'b0;
                    m_err   <= 1'b0;
                    busy    <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    m_ready <= 1'b0;
                    m_err   <= 1'b0;
                    busy    <= 1'b0;
                    s_we    <= {NSLV{1'b0}};
                    s_re    <= {NSLV{1'b0}};
                end
            endcase
        end
    end

endmodule
